puf_readout_ctrl: RTL
=====================

# puf_readout_ctrl

Host-side readout controller for the one-bit PUF cell inside the TinyTapeout wrapper. It drives challenges and the enable strobe into the PUF, then samples the asynchronous 1-bit response through a synchronizer. Each bit is decided by majority vote over repeated samples, and eight bits are packed into a word presented on a valid/ready handshake. It is the consumer end of the PUF challenge/response interface, and sits between the PUF cell and the wrapper's `uo_out`/`uio_*` pins.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 16. Cycles `puf_en` is held high before sampling. Must be ≥ 2 to cover synchronizer latency.
- `VOTES`, default 7. Samples per bit. Must be odd and ≥ 1.
- `WORD_W`, default 8. Response bits per word. Also the width of `challenge` and `chal_out`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one word readout; sampled only in IDLE.
- `challenge` in WORD_W: base challenge, latched when `start` is accepted.
- `puf_en` out 1: arms the PUF cell.
- `chal_out` out WORD_W: challenge currently applied to the PUF.
- `puf_bit` in 1: raw asynchronous PUF response.
- `word` out WORD_W: decided response; bit i is the response to challenge base+i.
- `unstable` out WORD_W: bit i is set when the votes for bit i were not unanimous.
- `word_valid` out 1: `word` and `unstable` are valid.
- `word_ready` in 1: downstream accepts the word.
- `busy` out 1: high in every state except IDLE.

## Operation
FSM states: IDLE, ARM, SAMPLE, DECIDE, PRESENT.
- **IDLE**
  - `start`=1 → latch `challenge` into `base`; clear bit index, `word` and `unstable`; go to ARM.
- **ARM**
  - `puf_en`=1 and `chal_out`=`base`+`idx` (mod 2^WORD_W).
  - Stays for SETTLE_CYCLES cycles, then goes to SAMPLE with the ones-counter cleared.
- **SAMPLE**
  - `puf_en`=1; `chal_out` is unchanged.
  - Each cycle adds the synchronized bit (`puf_sync2` output) to the ones-counter.
  - After VOTES cycles, go to DECIDE.
- **DECIDE**
  - `puf_en`=0 for one cycle.
  - `word[idx]` = (ones > VOTES/2).
  - `unstable[idx]` = (ones ≠ 0 and ones ≠ VOTES).
  - If `idx`=WORD_W−1, go to PRESENT; otherwise increment `idx` and go to ARM.
- **PRESENT**
  - `word_valid`=1; `word` and `unstable` are held stable.
  - `word_valid`&`word_ready` → go to IDLE; `word_valid`=0 from the next cycle.
- Counter widths:
  - ones-counter: $clog2(VOTES+1).
  - settle/sample counter: $clog2(max(SETTLE_CYCLES,VOTES)+1).
  - `idx`: $clog2(WORD_W).
- No counter wraps within a phase. `chal_out` wraps modulo 2^WORD_W, so `base`=0xFE gives FE, FF, 00, ….

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - state=IDLE;
  - `puf_en`, `word_valid`, `busy` = 0;
  - `word`, `unstable`, `chal_out` = 0;
  - synchronizer flops = 0.
- Cycle after `start` is accepted: state ARM, `busy`=1, `puf_en`=1.
- Per bit: SETTLE_CYCLES + VOTES + 1 cycles. With defaults, 24 cycles per bit and 192 cycles from `start` acceptance to `word_valid`=1.
- Synchronizer latency is 2 cycles. A sample taken in SAMPLE cycle k reflects `puf_bit` as it was 2 cycles earlier.
- Boundary conditions:
  - `start` outside IDLE is ignored, including in the cycle of the PRESENT handshake. A `start` held high is accepted on the first IDLE cycle.
  - `word_ready` may be high before `word_valid` rises. The handshake then completes in the first PRESENT cycle.
  - `word_ready` low keeps the controller in PRESENT indefinitely with outputs frozen and `puf_en`=0.
  - `rst_n` low mid-operation aborts the readout immediately. The next readout restarts from bit 0 with a freshly latched challenge.

## Structure
- Package `puf_pkg`:
  - state enum `puf_rd_state_t` (IDLE, ARM, SAMPLE, DECIDE, PRESENT);
  - default constants `PUF_SETTLE_DEF`=16, `PUF_VOTES_DEF`=7, `PUF_WORD_W_DEF`=8.
- Sub-module `puf_sync2`: two-flop synchronizer with async active-low reset to 0, instantiated on `puf_bit`.
- `puf_readout_ctrl`: FSM, counters and the packing register.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle → all outputs 0 within the same cycle; after release, `busy`=0 and `word_valid`=0.
- **Constant one:** `puf_bit`=1, `start` with `challenge`=0xF0 → `chal_out` steps F0..F7; `word_valid` rises 192 cycles after acceptance; `word`=0xFF, `unstable`=0x00.
- **Challenge-dependent response:** `puf_bit`=`chal_out[0]`, `challenge`=0x00 → `word`=0xAA, `unstable`=0x00. Repeat with `challenge`=0xFE to check wrap; `chal_out` goes FE, FF, 00..05.
- **Noisy vote:** during the bit-3 SAMPLE phase, drive the synchronized samples as 1,1,0,1,0,1,1 (applied 2 cycles early), other bits constant 0 → `word`=0x08, `unstable`=0x08.
- **Backpressure:** hold `word_ready`=0 for 50 cycles after `word_valid`, and pulse `start` during that time → `word` stable, `word_valid` held, `start` ignored. Raise `word_ready` → `word_valid`=0 and `busy`=0 next cycle.
- **Reset mid-operation:** pulse `rst_n` low during bit 4 → outputs 0. A new `start` with `challenge`=0x10 → `chal_out` restarts at 0x10 and a full 192-cycle readout follows.

Source files
------------

// File: rtl/puf_readout_ctrl_pkg.sv
// Shared types and default sizing for the PUF readout controller.
// Holds the FSM state encoding and the parameter defaults used by the top and its interface.
package puf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SAMPLE,
      DECIDE,
      PRESENT
   } puf_rd_state_t;

   localparam int PUF_SETTLE_DEF = 16;
   localparam int PUF_VOTES_DEF  = 7;
   localparam int PUF_WORD_W_DEF = 8;

endpackage

// File: rtl/puf_readout_ctrl_if.sv
// Word output handshake of the PUF readout controller (valid/ready plus payload).
// The controller is the master; the downstream consumer is the slave.
interface puf_readout_ctrl_if
   import puf_pkg::*;
#(
   parameter int WORD_W = PUF_WORD_W_DEF
);
   logic [WORD_W-1:0] word;
   logic [WORD_W-1:0] unstable;
   logic              word_valid;
   logic              word_ready;

   modport master (
      output word,
      output unstable,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word,
      input  unstable,
      input  word_valid,
      output word_ready
   );
endinterface

// File: rtl/puf_readout_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous PUF response into the clk domain.
module puf_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/puf_readout_ctrl.sv
// PUF readout controller: arms the PUF per challenge, majority-votes synchronized samples
// into one bit per challenge, and presents the packed word on a valid/ready handshake.
module puf_readout_ctrl
   import puf_pkg::*;
#(
   parameter int SETTLE_CYCLES = PUF_SETTLE_DEF,
   parameter int VOTES         = PUF_VOTES_DEF,
   parameter int WORD_W        = PUF_WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] challenge,
   output logic              puf_en,
   output logic [WORD_W-1:0] chal_out,
   input  logic              puf_bit,
   output logic              busy,
   puf_readout_ctrl_if.master rsp
);
   localparam int CNT_MAX = (SETTLE_CYCLES > VOTES) ? SETTLE_CYCLES : VOTES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int ONES_W  = $clog2(VOTES + 1);
   localparam int IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  VOTES_LAST  = CNT_W'(VOTES - 1);
   localparam logic [ONES_W-1:0] ONES_ALL    = ONES_W'(VOTES);
   localparam logic [ONES_W-1:0] ONES_HALF   = ONES_W'(VOTES / 2);
   localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(WORD_W - 1);

   puf_rd_state_t     state, next_state;
   logic [CNT_W-1:0]  cnt;
   logic [ONES_W-1:0] ones;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] word_q;
   logic [WORD_W-1:0] unstable_q;
   logic              puf_s;

   puf_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (puf_bit),
      .q     (puf_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state     = state;
      puf_en         = 1'b0;
      busy           = 1'b1;
      rsp.word_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) next_state = ARM;
         end
         ARM: begin
            puf_en = 1'b1;
            if (cnt == SETTLE_LAST) next_state = SAMPLE;
         end
         SAMPLE: begin
            puf_en = 1'b1;
            if (cnt == VOTES_LAST) next_state = DECIDE;
         end
         DECIDE: begin
            next_state = (idx == IDX_LAST) ? PRESENT : ARM;
         end
         PRESENT: begin
            rsp.word_valid = 1'b1;
            if (rsp.word_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // chal_out doubles as base+idx: loaded with the base challenge and stepped once per decided bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         ones       <= '0;
         idx        <= '0;
         word_q     <= '0;
         unstable_q <= '0;
         chal_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  chal_out   <= challenge;
                  idx        <= '0;
                  cnt        <= '0;
                  word_q     <= '0;
                  unstable_q <= '0;
               end
            end
            ARM: begin
               if (cnt == SETTLE_LAST) begin
                  cnt  <= '0;
                  ones <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SAMPLE: begin
               ones <= ones + ONES_W'(puf_s);
               cnt  <= (cnt == VOTES_LAST) ? '0 : cnt + CNT_W'(1);
            end
            DECIDE: begin
               word_q[idx]     <= (ones > ONES_HALF);
               unstable_q[idx] <= (ones != '0) && (ones != ONES_ALL);
               if (idx != IDX_LAST) begin
                  idx      <= idx + IDX_W'(1);
                  chal_out <= chal_out + WORD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp.word     = word_q;
   assign rsp.unstable = unstable_q;
endmodule
